// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard scoreboard.
// Tuse/Tnew encodings, forward selects, per-class Tnew values.
package hazard_scoreboard_pkg;

  localparam int HS_AW = 5;
  localparam int HS_TW = 2;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D-stage selects: RF / E / M.  E-stage selects: pipe / M / W.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd2;
  localparam logic [1:0] FWD_XM = 2'd1;

  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_MDRD = 2'd1;

endpackage

// File: rtl/hazard_scoreboard_src_check.sv
// One source operand against the E/M producers:
// stall request plus D-stage forward select.
module hazard_src_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = HS_AW,
  parameter int TW = HS_TW
) (
  input  logic [AW-1:0] src_i,
  input  logic [TW-1:0] tuse_i,
  input  logic [AW-1:0] e_wa_i,
  input  logic [TW-1:0] e_tnew_i,
  input  logic [AW-1:0] m_wa_i,
  input  logic [TW-1:0] m_tnew_i,
  output logic          stall_o,
  output logic [1:0]    fwd_o
);

  logic used;
  logic e_hit;
  logic m_hit;

  assign used  = (tuse_i != {TW{1'b1}});
  assign e_hit = (|src_i) && (e_wa_i == src_i);
  assign m_hit = (|src_i) && (m_wa_i == src_i);

  assign stall_o = used &&
    ((e_hit && (e_tnew_i > tuse_i)) ||
     (m_hit && (m_tnew_i > tuse_i)));

  // Youngest ready producer wins.
  always_comb begin
    fwd_o = FWD_RF;
    if (e_hit && (e_tnew_i == '0))
      fwd_o = FWD_E;
    else if (m_hit && (m_tnew_i == '0))
      fwd_o = FWD_M;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks E/M/W destinations and Tnew; drives the
// D-stage stall and the D/E forwarding selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = HS_AW,
  parameter int TW = HS_TW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] D_Rs,
  input  logic [AW-1:0] D_Rt,
  input  logic [TW-1:0] D_TuseRs,
  input  logic [TW-1:0] D_TuseRt,
  input  logic [AW-1:0] D_WA,
  input  logic [TW-1:0] D_Tnew,
  input  logic          D_IsMD,
  input  logic          MD_Start,
  input  logic          MD_Busy,
  output logic          Stall,
  output logic [1:0]    D_FwdRs,
  output logic [1:0]    D_FwdRt,
  output logic [1:0]    E_FwdRs,
  output logic [1:0]    E_FwdRt
);

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] wa;
    logic [TW-1:0] tnew;
  } e_rec_t;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [TW-1:0] tnew;
  } m_rec_t;

  e_rec_t        e_q, e_d;
  m_rec_t        m_q, m_d;
  logic [AW-1:0] w_wa_q;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  hazard_src_check #(.AW(AW), .TW(TW)) u_rs (
    .src_i    (D_Rs),
    .tuse_i   (D_TuseRs),
    .e_wa_i   (e_q.wa),
    .e_tnew_i (e_q.tnew),
    .m_wa_i   (m_q.wa),
    .m_tnew_i (m_q.tnew),
    .stall_o  (stall_rs),
    .fwd_o    (D_FwdRs)
  );

  hazard_src_check #(.AW(AW), .TW(TW)) u_rt (
    .src_i    (D_Rt),
    .tuse_i   (D_TuseRt),
    .e_wa_i   (e_q.wa),
    .e_tnew_i (e_q.tnew),
    .m_wa_i   (m_q.wa),
    .m_tnew_i (m_q.tnew),
    .stall_o  (stall_rt),
    .fwd_o    (D_FwdRt)
  );

  assign stall_md = D_IsMD && (MD_Start || MD_Busy);
  assign Stall    = stall_rs || stall_rt || stall_md;

  function automatic logic [1:0] e_fwd(
    input logic [AW-1:0] src,
    input logic [AW-1:0] mwa,
    input logic [TW-1:0] mtn,
    input logic [AW-1:0] wwa
  );
    e_fwd = FWD_RF;
    if ((|src) && (mwa == src) && (mtn == '0))
      e_fwd = FWD_XM;
    else if ((|src) && (wwa == src))
      e_fwd = FWD_W;
  endfunction

  assign E_FwdRs = e_fwd(e_q.rs, m_q.wa, m_q.tnew, w_wa_q);
  assign E_FwdRt = e_fwd(e_q.rt, m_q.wa, m_q.tnew, w_wa_q);

  always_comb begin
    e_d = '0;
    if (!Stall) begin
      e_d.rs   = D_Rs;
      e_d.rt   = D_Rt;
      e_d.wa   = D_WA;
      e_d.tnew = D_Tnew;
    end
    m_d.wa   = e_q.wa;
    m_d.tnew = (e_q.tnew == '0) ? '0 :
      e_q.tnew - {{(TW-1){1'b0}}, 1'b1};
  end

  // W only needs its address: its tnew is always 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_wa_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_wa_q <= m_q.wa;
    end
  end

endmodule
